stack_access_arbiter: RTL and testbench
=======================================

// Module: stack_access_arbiter
// PURPOSE
//  - Shares the single 16x16 LIFO stack between two requesters: req0 = EX-stage PUSH/POP, req1 = CALL/RET/interrupt unit.
//  - Arbitrates, screens overflow/underflow, and issues exactly one one-cycle enable pulse per accepted operation.
//  - Returns pop data/status to the originating requester and maintains an occupancy count.
// PARAMETERS
//  DATA_W    16  stack word width
//  DEPTH     16  stack entries; occupancy counter range 0..DEPTH
//  ARB_MODE  0   0 = round-robin, 1 = fixed priority (req0 wins)
// PORTS
//  clk                  in   1                   system clock; all state on posedge
//  reset                in   1                   synchronous, active-high
//  req_valid            in   2                   per-requester request valid
//  req_op               in   2                   per-requester op: 0 = push, 1 = pop
//  req_data             in   2*DATA_W            push data; [DATA_W-1:0] = req0
//  req_ready            out  2                   grant; handshake = valid & ready at posedge
//  rsp_valid            out  2                   one-cycle response pulse to the originator
//  rsp_data             out  DATA_W              popped word; 0 for push or error
//  rsp_err              out  1                   1 = push-when-full or pop-when-empty; qualified by rsp_valid
//  stack_depth          out  $clog2(DEPTH+1)     current occupancy
//  Stack_In_Enable_EX   out  1                   push strobe to stack
//  Stack_Out_Enable_EX  out  1                   pop strobe to stack
//  Stack_In_EX          out  DATA_W              push data to stack
//  Stack_Out_EX         in   DATA_W              pop data from stack; valid after the stack's negedge update
//  Empty, Full          in   1                   stack status flags
// BEHAVIOUR
//  Reset (sync, high):
//   - state=IDLE; rr pointer=req0 favoured; req_ready=0; rsp_valid=0; rsp_data=0; rsp_err=0; stack_depth=0.
//   - Both stack enables low while reset is high. Stack_In_EX=0.
//  FSM, per op (one op per 3 cycles max; no pipelining):
//   - IDLE -> ISSUE -> RESP -> IDLE.
//  IDLE:
//   - req_ready is combinational: one-hot to the arbitration winner among valid requesters; 0 if none valid.
//   - On handshake: latch id/op/data.
//   - err = (push & Full) | (pop & Empty), sampled from stack flags this cycle; latch it. Go to ISSUE.
//  ISSUE:
//   - Stack_In_Enable_EX = push & !err; Stack_Out_Enable_EX = pop & !err.
//   - Enables are decoded from registered state/op only, high for exactly this cycle.
//   - Stack_In_EX = latched data during ISSUE, else 0.
//   - At posedge ending ISSUE: rsp_data <= (pop & !err) ? Stack_Out_EX : 0.
//   - At the same posedge: stack_depth += 1 for push, -= 1 for pop, unchanged if err.
//   - Then go to RESP.
//  RESP:
//   - rsp_valid[id]=1 for this cycle only, with rsp_data and rsp_err held stable; req_ready=0. Go to IDLE.
//   - rsp_data/rsp_err hold their value until the next RESP.
//  Latency:
//   - accept at posedge N; stack strobe during cycle N+1; rsp_valid high in cycle N+2.
//   - Earliest next accept is IDLE in cycle N+3.
//  Arbitration:
//   - ARB_MODE=0: round-robin. The winner is the valid requester not granted last.
//   - The rr pointer updates only on a handshake.
//   - ARB_MODE=1: req0 always wins when valid.
//  Boundaries:
//   - Push at depth 15 is OK and Full then rises. A further push gives rsp_err=1, stack untouched, depth stays 16.
//   - Pop at depth 0 gives rsp_err=1 and rsp_data=0.
//   - Simultaneous push (req0) and pop (req1) are serialized in arbitration order.
//   - A requester may hold valid through RESP; it is re-arbitrated in the next IDLE.
//   - Reset mid-op, in ISSUE or RESP: the op is abandoned, no rsp_valid is produced, and the enables drop in the same cycle.
//   - Stack contents are the stack's own concern; stack_depth restarts at 0.
//  Assert: stack_depth==0 iff Empty, and stack_depth==DEPTH iff Full, checked in IDLE after reset.
// STRUCTURE
//  - Package stack_arb_pkg: state enum {IDLE, ISSUE, RESP}, OP_PUSH=1'b0, OP_POP=1'b1, REQ_N=2.
//  - Sub-module rr_arbiter_2: 2-way round-robin/fixed arbiter, valid[1:0] + advance -> grant[1:0].
//  - Remainder in top: FSM, latches, depth counter.
// TESTING
//  1. req0 push 0x00A5 from reset -> ready0 cycle 0; In_Enable pulse cycle 1; rsp_valid=2'b01, err=0 cycle 2; depth=1.
//  2. Push 0x1111 then pop via req1 -> pop rsp_valid=2'b10, rsp_data=0x1111, err=0; depth back to 0, Empty=1.
//  3. Both valid every cycle, ARB_MODE=0, 4 pushes -> grants alternate 01,10,01,10; ops spaced exactly 3 cycles.
//  4. 16 pushes then a 17th push -> first 16 err=0, Full=1; 17th err=1, no In_Enable pulse, depth=16.
//  5. Pop from empty -> rsp_err=1, rsp_data=0, Out_Enable never high; ARB_MODE=1 with both valid -> req0 granted 3 times running.
//  6. reset asserted during ISSUE of a pop -> enables low that cycle, no rsp_valid; state IDLE, depth 0 next cycle.

Source files
------------

// File: rtl/stack_arb_pkg.sv
// rtl/stack_arb_pkg.sv - shared types and constants for the stack access arbiter
package stack_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;
  localparam int   REQ_N   = 2;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin / fixed-priority arbiter
module rr_arbiter_2 #(
  parameter int ARB_MODE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // set when req1 took the last grant; reset value favours req0
  logic last_was_1;

  always_comb begin
    grant = 2'b00;
    if (ARB_MODE == 1) begin
      if (valid[0])      grant = 2'b01;
      else if (valid[1]) grant = 2'b10;
    end else begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_was_1 ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        last_was_1 <= 1'b1;
    else if (advance) last_was_1 <= grant[1];
  end

endmodule

// File: rtl/stack_access_arbiter.sv
// rtl/stack_access_arbiter.sv - shares one LIFO stack between two requesters
module stack_access_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 16,
  parameter int ARB_MODE = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [REQ_N-1:0]            req_valid,
  input  logic [REQ_N-1:0]            req_op,
  input  logic [REQ_N*DATA_W-1:0]     req_data,
  output logic [REQ_N-1:0]            req_ready,
  output logic [REQ_N-1:0]            rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_err,
  output logic [$clog2(DEPTH+1)-1:0]  stack_depth,
  output logic                        Stack_In_Enable_EX,
  output logic                        Stack_Out_Enable_EX,
  output logic [DATA_W-1:0]           Stack_In_EX,
  input  logic [DATA_W-1:0]           Stack_Out_EX,
  input  logic                        Empty,
  input  logic                        Full
);

  state_t              state, state_nx;
  logic [1:0]          grant;
  logic                handshake;
  logic                sel_id, sel_op, sel_err;
  logic                lat_id, lat_op, lat_err;
  logic [DATA_W-1:0]   lat_data;

  rr_arbiter_2 #(.ARB_MODE(ARB_MODE)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid   (req_valid),
    .advance (handshake),
    .grant   (grant)
  );

  // every strobe is gated by reset so an abandoned op drops its enables at once
  always_comb begin
    state_nx            = state;
    req_ready           = '0;
    rsp_valid           = '0;
    handshake           = 1'b0;
    Stack_In_Enable_EX  = 1'b0;
    Stack_Out_Enable_EX = 1'b0;
    Stack_In_EX         = '0;
    sel_id              = grant[1];
    sel_op              = req_op[sel_id];
    sel_err             = (sel_op == OP_PUSH) ? Full : Empty;
    if (!reset) begin
      case (state)
        IDLE: begin
          req_ready = grant;
          if (|grant) begin
            handshake = 1'b1;
            state_nx  = ISSUE;
          end
        end
        ISSUE: begin
          Stack_In_Enable_EX  = (lat_op == OP_PUSH) && !lat_err;
          Stack_Out_Enable_EX = (lat_op == OP_POP) && !lat_err;
          Stack_In_EX         = lat_data;
          state_nx            = RESP;
        end
        RESP: begin
          rsp_valid[lat_id] = 1'b1;
          state_nx          = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_id      <= 1'b0;
      lat_op      <= OP_PUSH;
      lat_err     <= 1'b0;
      lat_data    <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      stack_depth <= '0;
    end else begin
      if (handshake) begin
        lat_id   <= sel_id;
        lat_op   <= sel_op;
        lat_err  <= sel_err;
        lat_data <= sel_id ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
      end
      // the stack has updated its output on the preceding negedge
      if (state == ISSUE) begin
        rsp_err  <= lat_err;
        rsp_data <= ((lat_op == OP_POP) && !lat_err) ? Stack_Out_EX : '0;
        if (!lat_err) begin
          if (lat_op == OP_PUSH) stack_depth <= stack_depth + 1'b1;
          else                   stack_depth <= stack_depth - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stack_access_arbiter.sv
// tb/tb_stack_access_arbiter.sv - self-checking bench for stack_access_arbiter
module tb_stack_access_arbiter;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00, req_op = 2'b00;
  logic [31:0] req_data = '0;
  logic [1:0]  req_ready, rsp_valid;
  logic [15:0] rsp_data, Stack_In_EX;
  logic        rsp_err, Stack_In_Enable_EX, Stack_Out_Enable_EX;
  logic [4:0]  stack_depth;
  logic        Empty, Full;
  logic [15:0] s_out = '0;

  logic [1:0]  v1_valid = 2'b00, v1_op = 2'b11;
  logic [31:0] v1_data = '0;
  logic [1:0]  r1_ready, r1_rsp_valid;
  logic [15:0] r1_rsp_data, r1_stack_in;
  logic        r1_rsp_err, r1_in_en, r1_out_en;
  logic [4:0]  r1_depth;

  always #5 clk = ~clk;

  stack_access_arbiter #(.DATA_W(16), .DEPTH(DEPTH), .ARB_MODE(0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stack_depth(stack_depth), .Stack_In_Enable_EX(Stack_In_Enable_EX),
    .Stack_Out_Enable_EX(Stack_Out_Enable_EX), .Stack_In_EX(Stack_In_EX),
    .Stack_Out_EX(s_out), .Empty(Empty), .Full(Full)
  );

  // fixed-priority instance sees a permanently empty stack
  stack_access_arbiter #(.DATA_W(16), .DEPTH(DEPTH), .ARB_MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .req_valid(v1_valid), .req_op(v1_op), .req_data(v1_data),
    .req_ready(r1_ready), .rsp_valid(r1_rsp_valid), .rsp_data(r1_rsp_data), .rsp_err(r1_rsp_err),
    .stack_depth(r1_depth), .Stack_In_Enable_EX(r1_in_en),
    .Stack_Out_Enable_EX(r1_out_en), .Stack_In_EX(r1_stack_in),
    .Stack_Out_EX(16'h0000), .Empty(1'b1), .Full(1'b0)
  );

  // stack model: updates on negedge as the real stack does
  logic [15:0] smem [DEPTH];
  int scnt = 0;
  int n_in = 0, n_out = 0;
  assign Empty = (scnt == 0);
  assign Full  = (scnt == DEPTH);

  always @(negedge clk) begin
    if (reset) begin
      scnt = 0;
    end else begin
      if (Stack_In_Enable_EX) begin
        n_in++;
        if (scnt < DEPTH) begin smem[scnt] = Stack_In_EX; scnt++; end
      end
      if (Stack_Out_Enable_EX) begin
        n_out++;
        if (scnt > 0) begin scnt--; s_out = smem[scnt]; end
      end
    end
  end

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] arb(input logic [1:0] v, input logic last1, input int mode);
    if (v == 2'b00) return 2'b00;
    if (v != 2'b11) return v;
    if (mode == 1) return 2'b01;
    return last1 ? 2'b01 : 2'b10;
  endfunction

  // transaction-level reference: an accepted op strobes one cycle later and responds one after that
  int          ph = 0, m_depth = 0;
  logic        m_init = 1'b0, m_last = 1'b1;
  logic        m_id, m_op, m_err, m_rerr;
  logic [15:0] m_data, m_rsp;
  logic [15:0] m_stk [DEPTH];

  always @(negedge clk) begin : cmp
    logic [1:0] g;
    if (reset) begin
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_in_en", Stack_In_Enable_EX, 1'b0);
      chk("rst_out_en", Stack_Out_Enable_EX, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_stack_in", Stack_In_EX, 16'h0);
      ph = 0; m_last = 1'b1; m_depth = 0; m_rsp = '0; m_rerr = 1'b0; m_init = 1'b1;
    end else if (m_init) begin
      chk("depth", stack_depth, m_depth);
      chk("rsp_data_hold", rsp_data, m_rsp);
      chk("rsp_err_hold", rsp_err, m_rerr);
      case (ph)
        0: begin
          g = arb(req_valid, m_last, 0);
          chk("idle_ready", req_ready, g);
          chk("idle_en", {Stack_In_Enable_EX, Stack_Out_Enable_EX}, 2'b00);
          chk("idle_stack_in", Stack_In_EX, 16'h0);
          chk("idle_rsp_valid", rsp_valid, 2'b00);
          chk("empty_iff_zero", (stack_depth == 0), Empty);
          chk("full_iff_depth", (stack_depth == DEPTH), Full);
          if (g != 2'b00) begin
            m_id   = g[1];
            m_op   = req_op[m_id];
            m_data = m_id ? req_data[31:16] : req_data[15:0];
            m_err  = m_op ? (m_depth == 0) : (m_depth == DEPTH);
            m_last = m_id;
            ph     = 1;
          end
        end
        1: begin
          chk("issue_ready", req_ready, 2'b00);
          chk("issue_in_en", Stack_In_Enable_EX, !m_op && !m_err);
          chk("issue_out_en", Stack_Out_Enable_EX, m_op && !m_err);
          chk("issue_stack_in", Stack_In_EX, m_data);
          chk("issue_rsp_valid", rsp_valid, 2'b00);
          m_rsp = '0;
          if (!m_err) begin
            if (!m_op) begin m_stk[m_depth] = m_data; m_depth++; end
            else begin m_depth--; m_rsp = m_stk[m_depth]; end
          end
          m_rerr = m_err;
          ph = 2;
        end
        default: begin
          chk("resp_ready", req_ready, 2'b00);
          chk("resp_en", {Stack_In_Enable_EX, Stack_Out_Enable_EX}, 2'b00);
          chk("resp_valid", rsp_valid, m_id ? 2'b10 : 2'b01);
          ph = 0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 2'b00;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic do_op(input int id, input logic op, input logic [15:0] d,
                       output logic [1:0] rv, output logic [15:0] rd, output logic re);
    int n;
    req_valid = 2'b00; req_valid[id] = 1'b1; req_op[id] = op; req_data[id*16 +: 16] = d;
    n = 0;
    @(negedge clk);
    while (req_ready[id] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("op_granted", req_ready[id], 1'b1);
    tick();
    req_valid = 2'b00;
    n = 0;
    @(negedge clk);
    while (rsp_valid == 2'b00 && n < 10) begin @(negedge clk); n++; end
    chk("op_responded", |rsp_valid, 1'b1);
    rv = rsp_valid; rd = rsp_data; re = rsp_err;
    tick();
  endtask

  initial begin : stim
    logic [1:0]  rv;
    logic [15:0] rd;
    logic        re;
    int          k, cyc, n0;
    int          gcyc [4];
    logic [1:0]  gval [4];

    // single push from reset
    do_reset();
    req_valid = 2'b01; req_op = 2'b00; req_data[15:0] = 16'h00A5;
    @(negedge clk); chk("t1_ready_c0", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    @(negedge clk); chk("t1_in_en_c1", Stack_In_Enable_EX, 1'b1);
    chk("t1_stack_in_c1", Stack_In_EX, 16'h00A5);
    tick();
    @(negedge clk); chk("t1_rsp_valid_c2", rsp_valid, 2'b01); chk("t1_err_c2", rsp_err, 1'b0);
    tick();
    @(negedge clk); chk("t1_depth", stack_depth, 5'd1);
    tick();

    // push via req0 then pop via req1
    do_reset();
    do_op(0, 1'b0, 16'h1111, rv, rd, re);
    chk("t2_push_rv", rv, 2'b01); chk("t2_push_err", re, 1'b0);
    do_op(1, 1'b1, 16'h0000, rv, rd, re);
    chk("t2_pop_rv", rv, 2'b10); chk("t2_pop_data", rd, 16'h1111); chk("t2_pop_err", re, 1'b0);
    @(negedge clk); chk("t2_depth", stack_depth, 5'd0); chk("t2_empty", Empty, 1'b1);
    tick();

    // round-robin with both requesters asking every cycle
    do_reset();
    req_op = 2'b00; req_data = $urandom; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin gcyc[i] = 0; gval[i] = 2'b00; end
    k = 0; cyc = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin gval[k] = req_ready; gcyc[k] = cyc; k++; end
      cyc++;
    end
    tick(); req_valid = 2'b00;
    chk("t3_grant_count", k, 4);
    for (int i = 0; i < 4; i++) chk("t3_grant_order", gval[i], (i % 2) ? 2'b10 : 2'b01);
    for (int i = 1; i < 4; i++) chk("t3_spacing", gcyc[i] - gcyc[i-1], 3);
    repeat (4) tick();

    // fill to full, then one push too many
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      do_op(i % 2, 1'b0, 16'hC000 + 16'(i), rv, rd, re);
      chk("t4_push_err", re, 1'b0);
    end
    chk("t4_full", Full, 1'b1);
    chk("t4_depth16", stack_depth, 5'd16);
    n0 = n_in;
    do_op(0, 1'b0, 16'hDEAD, rv, rd, re);
    chk("t4_over_err", re, 1'b1);
    chk("t4_over_data", rd, 16'h0);
    chk("t4_no_in_en", n_in - n0, 0);
    chk("t4_depth_stays", stack_depth, 5'd16);

    // underflow, then fixed priority on the second instance
    do_reset();
    n0 = n_out;
    do_op(1, 1'b1, 16'h0000, rv, rd, re);
    chk("t5_under_err", re, 1'b1);
    chk("t5_under_data", rd, 16'h0);
    chk("t5_no_out_en", n_out - n0, 0);
    v1_valid = 2'b11;
    k = 0; cyc = 0; n0 = 0;
    while (k < 3 && cyc < 40) begin
      @(negedge clk);
      if (r1_ready != 2'b00) begin chk("t5_fixed_grant", r1_ready, 2'b01); k++; end
      if (r1_out_en) n0++;
      cyc++;
    end
    tick(); v1_valid = 2'b00;
    chk("t5_fixed_count", k, 3);
    chk("t5_fixed_no_out_en", n0, 0);
    repeat (3) tick();

    // reset during ISSUE of a pop
    do_reset();
    do_op(0, 1'b0, 16'hBEEF, rv, rd, re);
    req_valid = 2'b10; req_op[1] = 1'b1;
    k = 0;
    @(negedge clk);
    while (req_ready[1] !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    chk("t6_pop_granted", req_ready[1], 1'b1);
    tick();
    reset = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    chk("t6_out_en_low", Stack_Out_Enable_EX, 1'b0);
    chk("t6_in_en_low", Stack_In_Enable_EX, 1'b0);
    chk("t6_no_rsp", rsp_valid, 2'b00);
    tick();
    reset = 1'b0; req_valid = 2'b01; req_op[0] = 1'b0;
    @(negedge clk);
    chk("t6_no_rsp_after", rsp_valid, 2'b00);
    chk("t6_depth0", stack_depth, 5'd0);
    chk("t6_idle_ready", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    repeat (4) tick();

    // randomized traffic alternating push-heavy and pop-heavy stretches
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      req_valid = 2'($urandom);
      for (int r = 0; r < 2; r++)
        req_op[r] = ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      req_data = $urandom;
      tick();
    end
    req_valid = 2'b00;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
